// File: rtl/dense_requant_serializer.sv
// Captures a frame of IN_SIZE signed elements, requantizes each one with round-half-up and a right shift,
// clamps the result to DOUT_W bits and emits the elements one per cycle. Data and saturation counts are registered.
module dense_requant_serializer #(
    parameter int IN_SIZE = 64,
    parameter int DIN_W   = 16,
    parameter int DOUT_W  = 8,
    parameter int SHIFT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [IN_SIZE*DIN_W-1:0]     in_vector,
    output logic                         in_ready,
    output logic [DOUT_W-1:0]            out_data,
    output logic [$clog2(IN_SIZE)-1:0]   out_index,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         frame_done,
    output logic [$clog2(IN_SIZE):0]     sat_count
);

    localparam int IDX_W = $clog2(IN_SIZE);
    localparam int SAT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(IN_SIZE - 1);
    localparam logic signed [DIN_W:0]  RND      = (DIN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [DIN_W:0]  QMAX     = (DIN_W+1)'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [DIN_W:0]  QMIN     = ~QMAX;

    typedef enum logic {IDLE, STREAM} state_t;

    // Returns {saturated, value}; the sum is one bit wider than the input so rounding cannot wrap.
    function automatic logic [DOUT_W:0] requant(input logic [DIN_W-1:0] x);
        logic signed [DIN_W:0] sum;
        logic signed [DIN_W:0] r;
        sum = $signed({x[DIN_W-1], x}) + RND;
        r   = sum >>> SHIFT;
        if (r > QMAX) begin
            return {1'b1, QMAX[DOUT_W-1:0]};
        end else if (r < QMIN) begin
            return {1'b1, QMIN[DOUT_W-1:0]};
        end else begin
            return {1'b0, r[DOUT_W-1:0]};
        end
    endfunction

    state_t             state_q, state_d;
    logic [DIN_W-1:0]   buf_q [IN_SIZE];
    logic [DIN_W-1:0]   buf_d [IN_SIZE];
    logic [DOUT_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               frame_done_q, frame_done_d;
    logic [SAT_W-1:0]   sat_count_q, sat_count_d;
    logic               cur_sat_q, cur_sat_d;

    logic [IDX_W-1:0]   nxt_idx;
    logic [DOUT_W:0]    q_cap;
    logic [DOUT_W:0]    q_nxt;

    always_comb begin
        nxt_idx      = out_index_q + IDX_W'(1);
        q_cap        = requant(in_vector[DIN_W-1:0]);
        q_nxt        = requant(buf_q[nxt_idx]);
        state_d      = state_q;
        buf_d        = buf_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        sat_count_d  = sat_count_q;
        cur_sat_d    = cur_sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < IN_SIZE; i++) begin
                        buf_d[i] = in_vector[i*DIN_W +: DIN_W];
                    end
                    out_index_d = '0;
                    out_data_d  = q_cap[DOUT_W-1:0];
                    cur_sat_d   = q_cap[DOUT_W];
                    out_valid_d = 1'b1;
                    out_last_d  = (IN_SIZE == 1);
                    sat_count_d = '0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    sat_count_d = sat_count_q + SAT_W'(cur_sat_q);
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        out_index_d = nxt_idx;
                        out_data_d  = q_nxt[DOUT_W-1:0];
                        cur_sat_d   = q_nxt[DOUT_W];
                        out_last_d  = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sat_count_q  <= '0;
            cur_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            sat_count_q  <= sat_count_d;
            cur_sat_q    <= cur_sat_d;
        end
    end

    // Frame storage carries no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_dense_requant_serializer.sv
// Randomized scoreboard bench for dense_requant_serializer with directed timing, backpressure,
// overlap and mid-stream reset scenarios.
module tb_dense_requant_serializer;

    localparam int IN_SIZE = 64;
    localparam int DIN_W   = 16;
    localparam int DOUT_W  = 8;
    localparam int SHIFT   = 4;
    localparam int IDX_W   = $clog2(IN_SIZE);
    localparam int QMAX    = (2 ** (DOUT_W - 1)) - 1;
    localparam int QMIN    = -(2 ** (DOUT_W - 1));

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic [IN_SIZE*DIN_W-1:0]   in_vector = '0;
    logic                       in_ready;
    logic [DOUT_W-1:0]          out_data;
    logic [IDX_W-1:0]           out_index;
    logic                       out_valid;
    logic                       out_last;
    logic                       out_ready = 1'b1;
    logic                       frame_done;
    logic [IDX_W:0]             sat_count;

    dense_requant_serializer #(
        .IN_SIZE(IN_SIZE), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vector(in_vector),
        .in_ready(in_ready), .out_data(out_data), .out_index(out_index),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
    } exp_t;

    exp_t                      exp_q[$];
    int                        sat_q[$];
    int                        n_checks = 0;
    int                        n_fail = 0;
    bit                        bp_mode = 1'b0;
    bit                        ready_hold = 1'b1;
    bit                        pending_done = 1'b0;
    logic signed [DIN_W-1:0]   frame [IN_SIZE];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference: round half up, floor-divide by 2^SHIFT, then clamp.
    function automatic int q_ref(input int x, output bit sat);
        int v;
        int r;
        int c;
        v = x + (2 ** (SHIFT - 1));
        r = v / (2 ** SHIFT);
        if (v < 0 && (v % (2 ** SHIFT)) != 0) r = r - 1;
        c = (r > QMAX) ? QMAX : ((r < QMIN) ? QMIN : r);
        sat = (c != r);
        return c;
    endfunction

    function automatic logic signed [DIN_W-1:0] rand_elem();
        case ($urandom_range(0, 3))
            0: return DIN_W'($urandom_range(0, 300));
            1: return DIN_W'($urandom);
            2: return DIN_W'($urandom_range(2016, 2048));
            default: return DIN_W'(-int'($urandom_range(2040, 2075)));
        endcase
    endfunction

    always begin
        @(posedge clk);
        #2;
        out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
            check("frame_done", int'(frame_done), int'(pending_done));
            if (pending_done) begin
                if (sat_q.size() == 0) timeout("sat_queue_empty");
                else check("sat_count_end", int'(sat_count), sat_q.pop_front());
            end
            pending_done = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("out_index", int'(out_index), e.idx);
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_last", int'(out_last), int'(e.idx == IN_SIZE - 1));
                    if (e.idx == IN_SIZE - 1) pending_done = 1'b1;
                end
            end
        end
    end

    // Called one step after a rising edge; returns one step after the capture edge.
    task automatic send_frame();
        int n;
        int sats;
        bit s;
        exp_t e;
        n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) timeout("wait_in_ready");
        sats = 0;
        for (int i = 0; i < IN_SIZE; i++) begin
            in_vector[i*DIN_W +: DIN_W] = frame[i];
            e.data = q_ref(int'(frame[i]), s);
            e.idx  = i;
            exp_q.push_back(e);
            sats += int'(s);
        end
        sat_q.push_back(sats);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_index(input int target);
        int n;
        n = 0;
        while (!(out_valid && int'(out_index) == target) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (!(out_valid && int'(out_index) == target)) timeout("wait_index");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready || exp_q.size() != 0) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int tab_in [6];
        int tab_out [6];
        bit s;
        tab_in  = '{7, 8, 100, 4000, -24, -5000};
        tab_out = '{0, 1, 6, 127, -1, -128};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sat_count", int'(sat_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Requantization table and cycle-exact streaming timing.
        for (int i = 0; i < IN_SIZE; i++) frame[i] = (i < 6) ? DIN_W'(tab_in[i]) : '0;
        send_frame();
        for (int k = 1; k <= IN_SIZE + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= IN_SIZE) begin
                check("stream_valid", int'(out_valid), 1);
                check("stream_last", int'(out_last), int'(k == IN_SIZE));
                if (k <= 6) check("requant_value", int'($signed(out_data)), tab_out[k-1]);
            end else begin
                check("done_pulse", int'(frame_done), 1);
                check("done_in_ready", int'(in_ready), 1);
                check("done_sat_count", int'(sat_count), 2);
            end
        end
        wait_idle();
        check("idle_hold_index", int'(out_index), IN_SIZE - 1);
        check("idle_hold_sat", int'(sat_count), 2);

        // Backpressure while index 10 is presented.
        for (int i = 0; i < IN_SIZE; i++) frame[i] = rand_elem();
        send_frame();
        wait_index(10);
        ready_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_index_stable", int'(out_index), 10);
            check("bp_data_stable", int'($signed(out_data)), q_ref(int'(frame[10]), s));
        end
        ready_hold = 1'b1;
        wait_idle();

        // New frame offered mid-stream must be ignored.
        for (int i = 0; i < IN_SIZE; i++) frame[i] = rand_elem();
        send_frame();
        wait_index(30);
        for (int i = 0; i < IN_SIZE; i++) in_vector[i*DIN_W +: DIN_W] = DIN_W'(-int'(frame[i]) + 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("overlap_in_ready", int'(in_ready), 0);
        wait_idle();

        // Reset in the middle of a frame.
        for (int i = 0; i < IN_SIZE; i++) frame[i] = rand_elem();
        send_frame();
        wait_index(20);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        sat_q.delete();
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_sat_count", int'(sat_count), 0);
        repeat (3) @(posedge clk);
        #1;

        // Clean frame after reset, then randomized traffic with random backpressure.
        for (int i = 0; i < IN_SIZE; i++) frame[i] = rand_elem();
        send_frame();
        check("post_rst_first_index", int'(out_index), 0);
        wait_idle();
        bp_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < IN_SIZE; i++) frame[i] = rand_elem();
            send_frame();
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        bp_mode = 1'b0;
        repeat (4) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_sat_queue_empty", sat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_requant_serializer.md
DENSE_REQUANT_SERIALIZER -- requirements
Module: dense_requant_serializer

Interface
REQ-001 Parameters SHALL be:
- IN_SIZE, default 64: elements per frame, matching the dense-layer output count.
- DIN_W, default 16: signed input element width.
- DOUT_W, default 8: signed output element width.
- SHIFT, default 4: requantization right-shift, at least 1.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  frame vector present.
- in_vector  in  IN_SIZE x DIN_W signed  ReLU'd dense-layer outputs.
- in_ready  out  1  block can accept a frame.
- out_data  out  DOUT_W signed  requantized element.
- out_index  out  clog2(IN_SIZE)  index of out_data.
- out_valid  out  1  out_data valid.
- out_last  out  1  current element is index IN_SIZE-1.
- out_ready  in  1  consumer accepts element.
- frame_done  out  1  one-cycle pulse after last element accepted.
- sat_count  out  clog2(IN_SIZE)+1  saturated elements in current/last frame.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and STREAM.
REQ-005 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-006 In IDLE, on in_valid=1 at an edge, the block SHALL capture all IN_SIZE elements into an internal buffer and move to STREAM. in_vector is don't-care after that edge.
REQ-007 On the capture edge the block SHALL also:
- set out_index to 0;
- load out_data with Q(element 0);
- set out_valid to 1;
- clear sat_count to 0.
Latency from capture to first valid element is 1 cycle.
REQ-008 Q(x) SHALL be computed as:
- r = (x + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, computed at DIN_W+1 bits so the add cannot overflow;
- r is clamped to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-009 An element SHALL count as saturated when the clamp changes its value.
REQ-010 sat_count SHALL increment by 1 on the edge where a saturated element is accepted (out_valid and out_ready both 1).
REQ-011 In STREAM, when out_valid=1, out_ready=1 and out_index<IN_SIZE-1, on the same edge:
- out_index increments by 1;
- out_data loads Q(buffer[out_index+1]).
There are no bubbles, so sustained throughput is 1 element per cycle.
REQ-012 In STREAM with out_ready=0, out_data, out_index, out_valid and out_last SHALL hold their values unchanged.
REQ-013 out_last SHALL equal 1 exactly when out_valid=1 and out_index=IN_SIZE-1.
REQ-014 On acceptance of the last element (out_valid, out_ready and out_last all 1), on that edge:
- out_valid clears to 0;
- the state returns to IDLE;
- frame_done is 1 for exactly the following cycle.
REQ-015 A new frame SHALL NOT be accepted before the edge after the return to IDLE, so minimum frame spacing is IN_SIZE+1 cycles.
REQ-016 in_valid asserted while in STREAM SHALL be ignored: the buffer is unchanged and nothing is queued.
REQ-017 out_data and out_index SHALL hold their last values while in IDLE.
REQ-018 sat_count SHALL hold its value in IDLE until the next capture.

Reset
REQ-019 An edge with rst_n=0 SHALL set:
- state to IDLE;
- out_valid, out_last and frame_done to 0;
- out_index, out_data and sat_count to 0;
- in_ready to 1 from the following cycle.
REQ-020 Reset asserted mid-STREAM SHALL abort the frame: no frame_done is produced and the remaining elements are discarded.
REQ-021 The buffer contents need no reset value.

Verification (DIN_W=16, DOUT_W=8, SHIFT=4, IN_SIZE=64)
REQ-022 Requant check:
- Stimulus: element values {7, 8, 100, 4000, -24, -5000} in indices 0..5, out_ready held at 1.
- Response: out_data = 0, 1, 6, 127, -1, -128.
- sat_count = 2 after the frame.
REQ-023 Streaming check:
- Stimulus: capture with in_valid at edge N, out_ready held at 1.
- Response: out_valid is 1 during cycles N+1..N+64; out_last only in cycle N+64; frame_done pulses in cycle N+65; in_ready is 1 again in cycle N+65.
REQ-024 Backpressure check:
- Stimulus: drop out_ready to 0 for 5 cycles while index 10 is presented.
- Response: out_index and out_data are stable for 5 cycles; the sequence then resumes at index 11 with no index skipped or duplicated.
REQ-025 Overlapping-frame check:
- Stimulus: pulse in_valid with different data during STREAM at index 30.
- Response: indices 31..63 still carry the original frame; the new data is never output.
REQ-026 Mid-stream reset check:
- Stimulus: rst_n=0 for 1 cycle at index 20.
- Response: the next cycle shows out_valid=0, in_ready=1, sat_count=0, with no frame_done.
- A following capture streams a clean index 0..63 sequence.
